// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall sequencer for the 5-stage RISC-V core
//   (IF/ID/EX/MEM/WB). Resolves the hazards that forwarding cannot cover:
//   data-memory wait, multi-cycle mul/div in EX, taken branch in EX and
//   load-use between EX and ID. Each cycle it raises per-stage stall (hold the
//   pipeline register) and flush (insert a bubble) controls.
//
//   Priority, highest first: MEM wait, mul/div, taken branch, load-use.
//
// Parameters
//   REGISTER_ADDR_WIDTH  register index width
//   MEM_TIMEOUT          consecutive dmem wait cycles before the sticky
//                        timeout flag is raised (>= 2)
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   rs1_ID, rs2_ID                source registers of the ID instruction
//   rs1_used_ID, rs2_used_ID      ID instruction actually reads rs1 / rs2
//   rd_EX, mem_read_EX            destination / load flag of the EX instruction
//   branch_taken_EX               EX resolved a taken branch or jump
//   md_start_EX, md_done          mul/div op in EX / its result is valid
//   dmem_req_MEM, dmem_ready      MEM data-memory request / completion
//   stall_IF..stall_MEM           hold PC, IF/ID, ID/EX, EX/MEM registers
//   flush_ID..flush_WB            bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
//   mem_timeout_err               sticky dmem timeout flag
//   ctrl_state                    FSM state (0 = run, 1 = mul/div wait)
//   loaduse_cnt, md_stall_cnt,
//   mem_stall_cnt, branch_flush_cnt
//                                 32-bit wrapping event counters
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, the four event counters are built and
//                       count the cycles in which their hazard case is the
//                       active one; when undefined the ports read 0 and no
//                       counter flops exist.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT         = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
  input  logic                           rs1_used_ID,
  input  logic                           rs2_used_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  input  logic                           mem_read_EX,
  input  logic                           branch_taken_EX,
  input  logic                           md_start_EX,
  input  logic                           md_done,
  input  logic                           dmem_req_MEM,
  input  logic                           dmem_ready,
  output logic                           stall_IF,
  output logic                           stall_ID,
  output logic                           stall_EX,
  output logic                           stall_MEM,
  output logic                           flush_ID,
  output logic                           flush_EX,
  output logic                           flush_MEM,
  output logic                           flush_WB,
  output logic                           mem_timeout_err,
  output logic [1:0]                     ctrl_state,
  output logic [31:0]                    loaduse_cnt,
  output logic [31:0]                    md_stall_cnt,
  output logic [31:0]                    mem_stall_cnt,
  output logic [31:0]                    branch_flush_cnt
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MD_WAIT = 2'd1;

  localparam int                CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  TIMEOUT_PRE = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             timeoutErr_q, timeoutErr_d;

  logic memWait;
  logic mdNeed;
  logic loadUse;
  logic memCase, mdCase, branchCase, loadUseCase;

  // Raw hazard conditions. The mul/div stall is sustained by the wait state
  // so that md_start_EX is only consulted on entry from S_RUN.
  always_comb begin
    memWait = dmem_req_MEM & ~dmem_ready;
    mdNeed  = 1'b0;
    if (state_q == S_RUN) begin
      mdNeed = md_start_EX & ~md_done;
    end else if (state_q == S_MD_WAIT) begin
      mdNeed = ~md_done;
    end
    loadUse = mem_read_EX & (rd_EX != '0) &
              ((rs1_used_ID & (rs1_ID == rd_EX)) |
               (rs2_used_ID & (rs2_ID == rd_EX)));
  end

  // One-hot selection of the single active hazard case. A branch only acts
  // when EX is not stalled, which is guaranteed once MEM wait and mul/div are
  // excluded; it also discards the ID instruction, so it beats load-use.
  always_comb begin
    memCase     = memWait;
    mdCase      = ~memWait & mdNeed;
    branchCase  = ~memWait & ~mdNeed & branch_taken_EX;
    loadUseCase = ~memWait & ~mdNeed & ~branch_taken_EX & loadUse;
  end

  // Outputs are forced low while reset is held so nothing stalls during or
  // right after an asynchronous reset.
  always_comb begin
    stall_IF  = ~rst & (memCase | mdCase | loadUseCase);
    stall_ID  = ~rst & (memCase | mdCase | loadUseCase);
    stall_EX  = ~rst & (memCase | mdCase);
    stall_MEM = ~rst & memCase;
    flush_ID  = ~rst & branchCase;
    flush_EX  = ~rst & (branchCase | loadUseCase);
    flush_MEM = ~rst & mdCase;
    flush_WB  = ~rst & memCase;
  end

  // Next state: a MEM wait freezes the FSM because the whole pipe is held;
  // illegal encodings fall back to S_RUN.
  always_comb begin
    state_d = S_RUN;
    if (state_q == S_RUN || state_q == S_MD_WAIT) begin
      if (memWait) begin
        state_d = state_q;
      end else if (mdNeed) begin
        state_d = S_MD_WAIT;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  // Wait counter saturates at the timeout value; the error flag is raised on
  // the same edge the counter reaches it and only reset clears it.
  always_comb begin
    waitCnt_d    = '0;
    timeoutErr_d = timeoutErr_q;
    if (memWait) begin
      waitCnt_d = (waitCnt_q >= TIMEOUT_VAL) ? TIMEOUT_VAL : waitCnt_q + 1'b1;
      if (waitCnt_q >= TIMEOUT_PRE) begin
        timeoutErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign ctrl_state      = state_q;
  assign mem_timeout_err = timeoutErr_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] loadUseCnt_q, mdStallCnt_q, memStallCnt_q, branchFlushCnt_q;

  // Event counters, one per hazard case, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadUseCnt_q     <= '0;
      mdStallCnt_q     <= '0;
      memStallCnt_q    <= '0;
      branchFlushCnt_q <= '0;
    end else begin
      loadUseCnt_q     <= loadUseCnt_q     + {31'd0, loadUseCase};
      mdStallCnt_q     <= mdStallCnt_q     + {31'd0, mdCase};
      memStallCnt_q    <= memStallCnt_q    + {31'd0, memCase};
      branchFlushCnt_q <= branchFlushCnt_q + {31'd0, branchCase};
    end
  end

  assign loaduse_cnt      = loadUseCnt_q;
  assign md_stall_cnt     = mdStallCnt_q;
  assign mem_stall_cnt    = memStallCnt_q;
  assign branch_flush_cnt = branchFlushCnt_q;
`else
  assign loaduse_cnt      = 32'd0;
  assign md_stall_cnt     = 32'd0;
  assign mem_stall_cnt    = 32'd0;
  assign branch_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Consumes ID source-register indices, EX-stage load/branch/mul-div status and MEM data-memory handshake.
- Drives per-stage stall (hold pipeline register) and flush (insert bubble) controls.
- Complements the forwarding logic: resolves only the hazards forwarding cannot cover (load-use, multi-cycle EX ops, memory wait, taken branch).

Parameters:
REGISTER_ADDR_WIDTH, 5, register index width
MEM_TIMEOUT, 64, consecutive dmem stall cycles before timeout error (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rs1_ID  in  REGISTER_ADDR_WIDTH  rs1 of instruction in ID
rs2_ID  in  REGISTER_ADDR_WIDTH  rs2 of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  REGISTER_ADDR_WIDTH  destination of instruction in EX
mem_read_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  EX resolved a taken branch/jump
md_start_EX  in  1  EX holds a mul/div op
md_done  in  1  mul/div result valid this cycle
dmem_req_MEM  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes access this cycle
stall_IF, stall_ID, stall_EX, stall_MEM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers
flush_ID  out  1  bubble into IF/ID
flush_EX  out  1  bubble into ID/EX
flush_MEM  out  1  bubble into EX/MEM
flush_WB  out  1  bubble into MEM/WB
mem_timeout_err  out  1  sticky timeout flag
ctrl_state  out  2  current FSM state

Behaviour:
- Reset: FSM=S_RUN, wait counter=0, mem_timeout_err=0; all stall/flush outputs evaluate to 0 while rst is high.
- FSM encoding: S_RUN=2'd0, S_MD_WAIT=2'd1; 2'd2/2'd3 illegal, recover to S_RUN next cycle. ctrl_state = state register.
- Stall/flush outputs are combinational from state and inputs. Priority, highest first:
  1. MEM wait (dmem_req_MEM & ~dmem_ready): stall_IF..stall_MEM=1, flush_WB=1, all other flushes 0. FSM holds its state.
  2. Mul/div: in S_RUN with md_start_EX & ~md_done, or in S_MD_WAIT with ~md_done: stall_IF/ID/EX=1, flush_MEM=1. In the md_done cycle: no stall, FSM returns to S_RUN. md_start_EX & md_done in the same cycle in S_RUN: no stall, no state change.
  3. Taken branch (branch_taken_EX with stall_EX=0): flush_ID=1, flush_EX=1, no stall.
  4. Load-use (mem_read_EX, rd_EX!=0, and (rs1_used_ID & rs1_ID==rd_EX) or (rs2_used_ID & rs2_ID==rd_EX)): stall_IF=stall_ID=1, flush_EX=1. Lasts exactly 1 cycle per load.
- Transition S_RUN->S_MD_WAIT on md_start_EX & ~md_done with no MEM wait.
- Branch overrides load-use: the ID instruction is discarded.
- Wait counter:
  - Increments each cycle MEM wait is active; clears when it is inactive; saturates at MEM_TIMEOUT.
  - mem_timeout_err sets in the cycle the counter reaches MEM_TIMEOUT; remains set until rst.
  - It does not alter stall behaviour.
- rst mid-operation (e.g. in S_MD_WAIT) returns to S_RUN immediately; no stall persists after reset.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds 32-bit wrapping outputs loaduse_cnt, md_stall_cnt, mem_stall_cnt, branch_flush_cnt.
  - Each increments once per cycle its priority case is the active one.
  - All reset to 0.
- Undefined: these ports still exist, tied to 0, and no counter flops are built.

Test Plan:
- Load x5 in EX (rd_EX=5, mem_read_EX=1); ID add with rs1_ID=5, rs1_used_ID=1 -> 1 cycle of stall_IF=stall_ID=flush_EX=1, then all 0. Same stimulus with rd_EX=0 -> no stall.
- md_start_EX=1 with md_done rising 4 cycles later -> stall_IF/ID/EX and flush_MEM high for 4 cycles, ctrl_state=1 during the wait, 0 after the done cycle. md_start_EX with md_done in the same cycle -> no stall.
- branch_taken_EX=1 concurrent with a load-use match -> flush_ID=flush_EX=1, stall_IF=stall_ID=0.
- dmem_req_MEM=1, dmem_ready=0 for 3 cycles during S_MD_WAIT -> all four stalls plus flush_WB for 3 cycles, ctrl_state stays 1. With MEM_TIMEOUT=4 and 4 wait cycles -> mem_timeout_err=1 and sticky after dmem_ready.
- Assert rst during S_MD_WAIT -> ctrl_state=0 and all outputs 0 asynchronously, with no stall after release.
- With HAZARD_PERF_CNT_EN, run the scenarios above -> loaduse_cnt=1, md_stall_cnt=4, mem_stall_cnt=3, branch_flush_cnt=1.
